// File: rtl/unpacker_pkg.sv
// Shared types and default sizing for the word-to-byte unpacker.
package unpacker_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_WORD_WIDTH = 256;
    localparam int BYTES_PER_WORD     = DEFAULT_WORD_WIDTH / DEFAULT_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

endpackage

// File: rtl/unpacker.sv
// Reads one wide word from a word FIFO and streams it LSB byte first into a byte FIFO.
//
// state | meaning
// IDLE  | no word held; strobe a read when the word FIFO has data
// WAIT  | read data arrives this cycle; capture it into the shift register
// SEND  | emit one byte per cycle the byte FIFO has room; back to IDLE after the last
module unpacker
    import unpacker_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_fifo_empty,
    output logic                  word_read_enable,
    input  logic                  byte_fifo_full,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  busy,
    output logic [15:0]           word_count
);

    localparam int NUM_BYTES = WORD_WIDTH / DATA_WIDTH;
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    state_t                 state;
    state_t                 state_nxt;
    logic [WORD_WIDTH-1:0]  shreg;
    logic [CNT_W-1:0]       byte_cnt;
    logic                   last_byte;

    assign last_byte = (byte_cnt == CNT_W'(NUM_BYTES - 1));
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt        = state;
        word_read_enable = 1'b0;
        case (state)
            IDLE: begin
                word_read_enable = !word_fifo_empty && !rst;
                if (word_read_enable) state_nxt = WAIT;
            end
            WAIT: state_nxt = SEND;
            SEND: begin
                if (!byte_fifo_full && last_byte) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // data_valid defaults low so it is only high on cycles a new byte was registered
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            byte_cnt   <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            word_count <= '0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                WAIT: begin
                    shreg    <= word_in;
                    byte_cnt <= '0;
                end
                SEND: begin
                    if (!byte_fifo_full) begin
                        data_out   <= shreg[DATA_WIDTH-1:0];
                        data_valid <= 1'b1;
                        shreg      <= shreg >> DATA_WIDTH;
                        byte_cnt   <= byte_cnt + 1'b1;
                        if (last_byte) word_count <= word_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unpacker.sv
// Randomized scoreboard bench for the unpacker: a queue-based word FIFO model feeds the DUT,
// every word's bytes are queued as expected output and checked by an independent monitor.
module tb_unpacker;

    localparam int DW  = 8;
    localparam int WW  = 256;
    localparam int NB  = WW / DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [WW-1:0] word_in;
    logic          word_fifo_empty;
    logic          word_read_enable;
    logic          byte_fifo_full;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          busy;
    logic [15:0]   word_count;

    unpacker #(.DATA_WIDTH(DW), .WORD_WIDTH(WW)) dut (
        .clk              (clk),
        .rst              (rst),
        .word_in          (word_in),
        .word_fifo_empty  (word_fifo_empty),
        .word_read_enable (word_read_enable),
        .byte_fifo_full   (byte_fifo_full),
        .data_out         (data_out),
        .data_valid       (data_valid),
        .busy             (busy),
        .word_count       (word_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    logic [WW-1:0] wq[$];
    logic [DW-1:0] exp_q[$];
    int          valid_cyc[$];
    int          rd_cyc[$];
    int          rx_in_word = 0;
    logic [15:0] exp_wc = 16'd0;
    logic        rand_full_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Word FIFO model: a read strobe seen at an edge returns the head word during the next cycle.
    initial begin
        word_in = '0;
        forever begin
            logic rd;
            @(posedge clk);
            rd = word_read_enable;
            #1;
            if (rd && wq.size() > 0) word_in = wq.pop_front();
            word_fifo_empty = (wq.size() == 0);
        end
    end

    always @(negedge clk) if (rand_full_en) byte_fifo_full = ($urandom_range(0, 3) == 0);

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (word_read_enable) begin
                rd_cyc.push_back(cyc);
                if (rst) chk("rd_en_during_rst", 32'(word_read_enable), 32'd0);
            end
            if (data_valid) begin
                valid_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 32'(data_out), 32'hFFFF_FFFF);
                end else begin
                    chk("byte", 32'(data_out), 32'(exp_q.pop_front()));
                    rx_in_word++;
                    if (rx_in_word == NB) begin
                        rx_in_word = 0;
                        exp_wc = exp_wc + 16'd1;
                    end
                    chk("word_count", 32'(word_count), 32'(exp_wc));
                end
            end
        end
    end

    task automatic push_word(input logic [WW-1:0] w);
        wq.push_back(w);
        for (int k = 0; k < NB; k++) exp_q.push_back(w[k*DW +: DW]);
        word_fifo_empty = 1'b0;
    endtask

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w;
        for (int i = 0; i < WW / 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    function automatic logic [WW-1:0] ramp_word(input logic [7:0] base);
        logic [WW-1:0] w;
        for (int k = 0; k < NB; k++) w[k*DW +: DW] = base + 8'(k);
        return w;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (n < budget) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0 && wq.size() == 0 && !busy && !word_read_enable) break;
            n++;
        end
        if (n >= budget) chk({name, "_timeout"}, 32'(n), 32'(budget - 1));
    endtask

    task automatic wait_bytes(input int target, input int budget);
        int n = 0;
        while (valid_cyc.size() < target && n < budget) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (n >= budget) chk("wait_bytes_timeout", 32'(valid_cyc.size()), 32'(target));
    endtask

    function automatic int count_consecutive(input int from, input int to);
        int c = 0;
        for (int i = from + 1; i <= to; i++) if (valid_cyc[i] - valid_cyc[i-1] == 1) c++;
        return c;
    endfunction

    initial begin
        rst             = 1'b1;
        word_fifo_empty = 1'b1;
        byte_fifo_full  = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_data_out",   32'(data_out),   32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_rd_en",      32'(word_read_enable), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // one ramp word, no backpressure
        valid_cyc.delete(); rd_cyc.delete();
        @(negedge clk);
        push_word(ramp_word(8'h00));
        wait_idle("single", 200);
        chk("single_bytes",  32'(valid_cyc.size()), 32'(NB));
        if (valid_cyc.size() == NB) chk("single_consec", 32'(count_consecutive(0, NB-1)), 32'(NB-1));
        chk("single_wc",     32'(word_count), 32'd1);
        chk("single_rd",     32'(rd_cyc.size()), 32'd1);
        chk("single_busy",   32'(busy), 32'd0);

        // stall for 3 cycles after the 5th byte
        valid_cyc.delete();
        @(negedge clk);
        push_word(ramp_word(8'h00));
        wait_bytes(5, 100);
        byte_fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #3;
            chk("stall_valid_low", 32'(data_valid), 32'd0);
        end
        byte_fifo_full = 1'b0;
        @(negedge clk);
        #3;
        chk("stall_resume", 32'(data_valid), 32'd1);
        wait_idle("stall", 200);
        chk("stall_bytes", 32'(valid_cyc.size()), 32'(NB));
        chk("stall_wc",    32'(word_count), 32'd2);

        // two words back-to-back
        valid_cyc.delete(); rd_cyc.delete();
        @(negedge clk);
        push_word(ramp_word(8'h40));
        push_word(ramp_word(8'h80));
        wait_idle("b2b", 300);
        chk("b2b_rd_pulses", 32'(rd_cyc.size()), 32'd2);
        if (rd_cyc.size() == 2) chk("b2b_rd_spacing", 32'(rd_cyc[1] - rd_cyc[0]), 32'd34);
        chk("b2b_bytes", 32'(valid_cyc.size()), 32'(2*NB));
        if (valid_cyc.size() == 2*NB) begin
            chk("b2b_bubble", 32'(valid_cyc[NB] - valid_cyc[NB-1]), 32'd3);
            chk("b2b_consec", 32'(count_consecutive(0, 2*NB-1)), 32'(2*NB-2));
        end

        // reset after the 10th byte
        valid_cyc.delete();
        @(negedge clk);
        push_word(ramp_word(8'h10));
        wait_bytes(10, 100);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete(); wq.delete();
        rx_in_word = 0;
        exp_wc = 16'd0;
        push_word(ramp_word(8'hAA));
        #3;
        chk("midrst_valid", 32'(data_valid), 32'd0);
        chk("midrst_dout",  32'(data_out),   32'd0);
        chk("midrst_busy",  32'(busy),       32'd0);
        chk("midrst_wc",    32'(word_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        valid_cyc.delete();
        wait_idle("after_rst", 200);
        chk("after_rst_bytes", 32'(valid_cyc.size()), 32'(NB));
        chk("after_rst_wc",    32'(word_count), 32'd1);

        // empty FIFO: nothing moves
        rd_cyc.delete(); valid_cyc.delete();
        begin
            int bad = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                #3;
                if (word_read_enable || data_valid || busy) bad++;
            end
            chk("empty_idle_cycles", 32'(bad), 32'd0);
        end

        // randomized words with random backpressure
        rand_full_en = 1'b1;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            push_word(rand_word());
            if ($urandom_range(0, 3) == 0) push_word(rand_word());
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        wait_idle("random", 8000);
        rand_full_en = 1'b0;
        byte_fifo_full = 1'b0;
        chk("random_wc", 32'(word_count), 32'(exp_wc));

        // word_count wrap
        @(negedge clk);
        #3;
        force dut.word_count = 16'hFFFF;
        #1;
        release dut.word_count;
        exp_wc = 16'hFFFF;
        chk("preload_wc", 32'(word_count), 32'h0000_FFFF);
        @(negedge clk);
        push_word(ramp_word(8'h55));
        wait_idle("wrap", 200);
        chk("wrap_wc", 32'(word_count), 32'd0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/unpacker.md
UNPACKER -- requirements
Module: unpacker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the byte width emitted per transfer.
REQ-002 SHALL have parameter WORD_WIDTH, default 256, the word width read from the word FIFO; it is a multiple of DATA_WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port word_in, input, WORD_WIDTH bits: read data from the word FIFO, valid one cycle after word_read_enable.
REQ-006 SHALL have port word_fifo_empty, input, 1 bit: high when the word FIFO holds no word.
REQ-007 SHALL have port word_read_enable, output, 1 bit: a one-cycle read strobe to the word FIFO.
REQ-008 SHALL have port byte_fifo_full, input, 1 bit: high when the downstream byte FIFO cannot accept a byte.
REQ-009 SHALL have port data_out, output, DATA_WIDTH bits: the registered byte for the byte FIFO.
REQ-010 SHALL have port data_valid, output, 1 bit: a registered write enable for the byte FIFO, high for exactly the cycles data_out is new.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 SHALL have port word_count, output, 16 bits: the number of fully emitted words, wrapping 0xFFFF->0x0000.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, WAIT, SEND.
REQ-014 In IDLE, word_read_enable SHALL be driven combinationally as (!word_fifo_empty && !rst); when it is high, the next state is WAIT, otherwise the FSM stays in IDLE.
REQ-015 word_read_enable SHALL be 0 in WAIT and in SEND, so at most one word is outstanding.
REQ-016 In WAIT, the FSM SHALL load word_in into a WORD_WIDTH shift register, clear the byte counter, and go to SEND unconditionally.
REQ-017 In SEND with byte_fifo_full low, the block SHALL register data_out <= shreg[DATA_WIDTH-1:0] and data_valid <= 1, shift shreg right by DATA_WIDTH, and increment the byte counter.
REQ-018 In SEND with byte_fifo_full high, the block SHALL set data_valid <= 0, hold data_out, shreg and the counter, and stay in SEND (a stall).
REQ-019 Byte order SHALL be LSB first: byte k (bits [8k+7:8k]) is emitted as the k-th byte, which inverts the byte-into-MSB packing on the write path.
REQ-020 The byte counter SHALL be $clog2(WORD_WIDTH/DATA_WIDTH) bits wide; on emitting the last byte (counter == WORD_WIDTH/DATA_WIDTH-1), the FSM SHALL return to IDLE and increment word_count.
REQ-021 Latency SHALL be: word_read_enable at cycle N, shreg loaded at the N+1 edge, first data_valid visible in cycle N+2 if the byte FIFO is not full.
REQ-022 With no stalls, a word SHALL produce 32 consecutive data_valid cycles; there is a 2-cycle bubble (IDLE, WAIT) between words.
REQ-023 data_valid SHALL be 0 in every cycle in which no new byte is registered, including IDLE and WAIT.
REQ-024 When word_fifo_empty rises while in SEND, the current word SHALL still complete, and the FSM then waits in IDLE.

Reset
REQ-025 When rst is high at a clock edge, the block SHALL set state=IDLE, shreg=0, counter=0, data_out=0, data_valid=0, word_count=0.
REQ-026 Reset mid-word SHALL discard the remaining bytes of the word, with no further data_valid until a new word is read.
REQ-027 word_read_enable SHALL be 0 during any cycle in which rst is high.

Structure
REQ-028 A shared package unpacker_pkg SHALL hold the state enumeration (IDLE, WAIT, SEND), the defaults DATA_WIDTH/WORD_WIDTH, and the constant BYTES_PER_WORD = WORD_WIDTH/DATA_WIDTH.
REQ-029 The block SHALL be a single module with no sub-module; the FSM, shift register and counters are flat.

Verification
REQ-030 One word, byte k = k (0x1F1E..0100), byte FIFO never full -> data_out = 0x00, 0x01, ... 0x1F on 32 consecutive data_valid cycles starting at N+2; word_count = 1; busy falls after the last byte.
REQ-031 Same word, byte_fifo_full high for 3 cycles after the 5th byte -> data_valid low for exactly those 3 cycles, no byte lost or duplicated, and sequence 0x00..0x1F intact.
REQ-032 Two words queued back-to-back -> word_read_enable pulses exactly twice, 34 cycles apart; 64 bytes come out in order, with a 2-cycle bubble between words.
REQ-033 rst asserted after the 10th byte -> all outputs reset next cycle; a new word 0xAA.. then yields 0xAA as the first byte and no stale bytes.
REQ-034 word_fifo_empty held high with rst low -> word_read_enable stays 0, data_valid stays 0, and busy stays 0 for 100 cycles.
REQ-035 Preload word_count = 0xFFFF via 65535 words (or force), then complete one more word -> word_count = 0x0000.
